// File: rtl/fetch_branch_unit.sv
// Instruction-fetch / branch-resolution sequencer: fetches the word at pc over a
// req/ack port, issues it over valid/ready and drives the PC block's jump controls.
module fetch_branch_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_pc,
    output logic       o_imem_req,
    output logic [7:0] o_imem_addr,
    input  logic       i_imem_ack,
    input  logic [8:0] i_imem_data,
    input  logic       i_alu_flag_valid,
    input  logic       i_alu_zero,
    input  logic       i_alu_neg,
    output logic [8:0] o_instr,
    output logic       o_instr_valid,
    input  logic       i_instr_ready,
    output logic       o_pc_en,
    output logic [7:0] o_pc_control,
    output logic [7:0] o_jump_offset,
    output logic       o_halted,
    output logic       o_fault
);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_imem_req;
    logic [7:0] r_imem_addr;
    logic [8:0] r_instr;
    logic       r_instr_valid;
    logic       r_halted;
    logic       r_fault;
    logic       r_z;
    logic       r_n;
    logic [7:0] r_cnt;

    logic [2:0] w_op;
    logic [5:0] w_imm;
    logic [7:0] w_offset8;
    logic [7:0] w_cnt_nxt;
    logic       w_z;
    logic       w_n;
    logic       w_is_halt;
    logic       w_taken;
    logic       w_retire;

    assign w_op      = r_instr[8:6];
    assign w_imm     = r_instr[5:0];
    assign w_offset8 = {{2{w_imm[5]}}, w_imm};
    assign w_cnt_nxt = r_cnt + 8'd1;

    // Flags are forwarded so a branch retiring alongside a flag strobe sees the new value.
    assign w_z       = i_alu_flag_valid ? i_alu_zero : r_z;
    assign w_n       = i_alu_flag_valid ? i_alu_neg  : r_n;
    assign w_is_halt = (w_op == 3'b100) && (w_imm == 6'd0);
    assign w_taken   = (w_op == 3'b101) || ((w_op == 3'b110) && w_z) || ((w_op == 3'b111) && w_n);

    // Reset in the retire cycle drops the instruction, so it also masks the pulse.
    assign w_retire  = (r_state == S_ISSUE) && r_instr_valid && i_instr_ready && !i_reset;

    assign o_pc_en       = w_retire && !w_is_halt;
    assign o_pc_control  = (o_pc_en && w_taken) ? 8'hFF : 8'h00;
    assign o_jump_offset = (o_pc_en && w_taken) ? w_offset8 : 8'h00;

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_imem_addr;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_halted      = r_halted;
    assign o_fault       = r_fault;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_FETCH;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= 8'h00;
            r_instr       <= 9'h000;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
            r_z           <= 1'b0;
            r_n           <= 1'b0;
            r_cnt         <= 8'h00;
        end else begin
            if (i_alu_flag_valid) begin
                r_z <= i_alu_zero;
                r_n <= i_alu_neg;
            end
            case (r_state)
                S_FETCH: begin
                    r_imem_addr <= i_pc;
                    r_imem_req  <= 1'b1;
                    r_cnt       <= 8'h00;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_imem_ack) begin
                        r_instr       <= i_imem_data;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_ISSUE;
                    end else if (w_cnt_nxt == TO_LIMIT) begin
                        // Give up on this request; FETCH re-reads the same pc.
                        r_cnt      <= w_cnt_nxt;
                        r_fault    <= 1'b1;
                        r_imem_req <= 1'b0;
                        r_state    <= S_FETCH;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_ISSUE: begin
                    if (w_retire) begin
                        r_instr_valid <= 1'b0;
                        if (w_is_halt) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_halted      <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_branch_unit.sv
// Randomized bench for fetch_branch_unit: the bench plays instruction memory and PC
// block, and predicts each retire from the instruction-set rules.
module tb_fetch_branch_unit;
    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] i_pc = 8'h00;
    logic       i_imem_ack = 1'b0;
    logic [8:0] i_imem_data = 9'h000;
    logic       i_alu_flag_valid = 1'b0;
    logic       i_alu_zero = 1'b0;
    logic       i_alu_neg = 1'b0;
    logic       i_instr_ready = 1'b0;
    logic       o_imem_req, o_instr_valid, o_pc_en, o_halted, o_fault;
    logic [7:0] o_imem_addr, o_pc_control, o_jump_offset;
    logic [8:0] o_instr;

    fetch_branch_unit #(.TIMEOUT(15)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_pc(i_pc),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
        .i_alu_flag_valid(i_alu_flag_valid), .i_alu_zero(i_alu_zero), .i_alu_neg(i_alu_neg),
        .o_instr(o_instr), .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
        .o_pc_en(o_pc_en), .o_pc_control(o_pc_control), .o_jump_offset(o_jump_offset),
        .o_halted(o_halted), .o_fault(o_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model state
    logic [8:0] mem [256];
    int   m_pc = 0;
    bit   mz, mn, m_fault, m_halted;
    logic [8:0] m_instr;
    int   req_cnt, lat, stall, n_retire, cyc, fv_cyc;
    bit   lat_set, stall_set;
    bit   exp_ack, exp_ret, exp_idle, exp_req, exp_zero;
    logic [7:0] last_off, last_ctrl;
    // stimulus overrides: -1 = random
    int   k_lat = -1, k_stall = -1, k_fv = -1, k_fz = -1, k_fn = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit pick(input int sel);
        return (sel >= 0) ? sel[0] : 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input bit rst);
        bit fv, fz, fn, ret, halt, taken, n_req;
        int off;
        logic [2:0] op;
        logic [5:0] imm;
        @(negedge clk);
        i_reset = rst;
        i_pc = m_pc[7:0];
        if (o_imem_req) begin
            if (!lat_set) begin
                lat = (k_lat >= 0) ? k_lat : (($urandom_range(0, 19) == 0) ? 99 : int'($urandom_range(0, 3)));
                lat_set = 1;
            end
            i_imem_ack = (lat == 0);
            if (lat > 0) lat--;
            i_imem_data = i_imem_ack ? mem[m_pc] : 9'($urandom);
        end else begin
            i_imem_ack = 1'($urandom_range(0, 1));   // must be ignored outside WAIT
            i_imem_data = 9'($urandom);
        end
        if (o_instr_valid) begin
            if (!stall_set) begin
                stall = (k_stall >= 0) ? k_stall : int'($urandom_range(0, 3));
                stall_set = 1;
            end
            i_instr_ready = (stall == 0);
            if (stall > 0) stall--;
        end else begin
            i_instr_ready = 1'($urandom_range(0, 1));
        end
        if (k_fv == 2) fv = o_instr_valid && i_instr_ready;
        else fv = (k_fv >= 0) ? k_fv[0] : ($urandom_range(0, 3) == 0);
        fz = pick(k_fz);
        fn = pick(k_fn);
        i_alu_flag_valid = fv; i_alu_zero = fz; i_alu_neg = fn;
        #1;
        if (rst) begin
            chk("pc_en_in_reset", 32'(o_pc_en), 0);
            m_fault = 0; m_halted = 0; mz = 0; mn = 0; req_cnt = 0;
            lat_set = 0; stall_set = 0; exp_ack = 0; exp_ret = 0; exp_req = 0;
            exp_idle = 1; exp_zero = 1; cyc = 0; fv_cyc = -1;
            return;
        end
        cyc++;
        if (exp_zero) begin
            chk("post_reset_a", {o_imem_req, o_imem_addr, o_instr, o_instr_valid}, 0);
            chk("post_reset_b", {o_pc_en, o_pc_control, o_jump_offset, o_halted, o_fault}, 0);
        end
        chk("fault", 32'(o_fault), 32'(m_fault));
        chk("halted", 32'(o_halted), 32'(m_halted));
        if (exp_ack) begin
            chk("valid_after_ack", 32'(o_instr_valid), 1);
            chk("req_after_ack", 32'(o_imem_req), 0);
        end
        if (exp_ret) begin
            chk("valid_after_retire", 32'(o_instr_valid), 0);
            chk("req_after_retire", 32'(o_imem_req), 0);
        end
        if (exp_idle) chk("req_fetch_gap", 32'(o_imem_req), 0);
        if (exp_req) chk("req_refetch", 32'(o_imem_req), 1);
        if (m_halted) chk("halt_quiet", {o_imem_req, o_instr_valid}, 0);
        if (o_imem_req) chk("imem_addr", 32'(o_imem_addr), 32'(m_pc));
        if (o_instr_valid) chk("instr", 32'(o_instr), 32'(m_instr));
        if (o_instr_valid && fv_cyc < 0) fv_cyc = cyc;

        ret = o_instr_valid && i_instr_ready;
        if (ret) begin
            op = m_instr[8:6];
            imm = m_instr[5:0];
            halt = (op == 3'd4) && (imm == 6'd0);
            taken = (op == 3'd5) || (op == 3'd6 && (fv ? fz : mz)) || (op == 3'd7 && (fv ? fn : mn));
            off = (imm >= 32) ? int'(imm) - 64 : int'(imm);
            chk("pc_en", 32'(o_pc_en), 32'(!halt));
            chk("pc_control", 32'(o_pc_control), taken ? 32'hFF : 0);
            chk("jump_offset", 32'(o_jump_offset), taken ? 32'(off & 255) : 0);
            last_off = o_jump_offset;
            last_ctrl = o_pc_control;
            if (halt) m_halted = 1;
            else m_pc = taken ? ((m_pc + 1 + off) % 256 + 256) % 256 : (m_pc + 1) % 256;
            stall_set = 0;
            n_retire++;
        end else begin
            chk("idle_pc_outs", {o_pc_en, o_pc_control, o_jump_offset}, 0);
        end

        n_req = (exp_ret && !m_halted) || exp_idle;
        exp_zero = 0;
        exp_ack = 0;
        exp_idle = 0;
        if (o_imem_req && i_imem_ack) begin
            m_instr = mem[m_pc];
            req_cnt = 0; lat_set = 0; exp_ack = 1;
        end else if (o_imem_req) begin
            req_cnt++;
            if (req_cnt == 15) begin
                m_fault = 1; exp_idle = 1; req_cnt = 0; lat_set = 0;
            end
        end
        if (fv) begin mz = fz; mn = fn; end
        exp_ret = ret;
        exp_req = n_req;
    endtask

    task automatic run_ret(input string tag, input int n, input int budget);
        int start = n_retire;
        for (int i = 0; i < budget && (n_retire - start) < n; i++) step(0);
        chk(tag, 32'(n_retire - start), 32'(n));
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 9'h001;
        step(1);
        step(1);
        chk("reset_outs_a", {o_imem_req, o_imem_addr, o_instr, o_instr_valid}, 0);
        chk("reset_outs_b", {o_pc_en, o_pc_control, o_jump_offset, o_halted, o_fault}, 0);

        // sequential fetch, ack on the first request cycle
        mem[0] = 9'b000_000001;
        m_pc = 0; k_lat = 0; k_stall = 0; k_fv = 0;
        run_ret("seq_retire", 1, 20);
        chk("seq_first_valid_cycle", 32'(fv_cyc), 3);

        // BZ -2 taken only through forwarded Z
        mem[1] = {3'b110, 6'b111110};
        k_fv = 2; k_fz = 1;
        run_ret("bz_retire", 1, 20);
        chk("bz_fwd_ctrl", 32'(last_ctrl), 32'hFF);
        chk("bz_fwd_off", 32'(last_off), 32'hFE);
        k_fz = 0;
        run_ret("bz_nt_retire", 2, 40);
        chk("bz_nt_ctrl", 32'(last_ctrl), 0);
        chk("bz_nt_off", 32'(last_off), 0);

        // JMP +3 from FE wraps to 02
        k_fv = 0;
        m_pc = 8'hFE;
        mem[8'hFE] = {3'b101, 6'd3};
        run_ret("jmp_retire", 1, 20);
        chk("jmp_off", 32'(last_off), 3);
        step(0);
        step(0);
        chk("jmp_wrap_addr", 32'(o_imem_addr), 2);

        // backpressure
        k_stall = 5;
        run_ret("stall_retire", 1, 30);

        // timeout, then normal completion with fault held
        k_stall = 0; k_lat = 99;
        for (int i = 0; i < 40 && !o_fault; i++) step(0);
        chk("timeout_fault", 32'(o_fault), 1);
        k_lat = 1;
        run_ret("after_timeout_retire", 1, 30);
        chk("fault_sticky", 32'(o_fault), 1);

        // randomized traffic over a random program (no HALT)
        for (int a = 0; a < 256; a++) begin
            mem[a] = 9'($urandom);
            if (mem[a] == 9'b100_000000) mem[a] = 9'b100_000001;
        end
        k_lat = -1; k_stall = -1; k_fv = -1; k_fz = -1; k_fn = -1;
        run_ret("random_retires", 300, 20000);

        // reset in the middle of WAIT
        k_lat = 99;
        for (int i = 0; i < 40 && !o_imem_req; i++) step(0);
        chk("wait_reached", 32'(o_imem_req), 1);
        step(0);
        step(0);
        step(1);
        k_lat = 1;
        run_ret("post_reset_retire", 1, 30);

        // HALT
        k_lat = -1; k_stall = -1;
        mem[m_pc] = 9'b100_000000;
        run_ret("halt_retire", 1, 60);
        for (int i = 0; i < 6; i++) step(0);
        chk("halted_final", 32'(o_halted), 1);
        chk("halted_no_req", 32'(o_imem_req), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
